mod12_count_checker: RTL and testbench

Receive-side monitor for the mod-12 up/down counter's `Count`/`UpOrDown` stream. It tracks the expected count and locks onto the stream after a run of consecutive correct samples. It flags sequence errors and reports up/down wrap events. It sits beside the counter in test and integration builds and gives a registered pass/fail view of the counter.

---
 rtl/mod12_count_checker_if.sv | 25 ++
 rtl/mod12_count_checker.sv | 172 +++++++++++++++++
 tb/tb_mod12_count_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mod12_count_checker_if.sv
// Monitor-side bundle for the mod-12 counter checker: sampled counter stream in,
// registered pass/fail and wrap indications out.
interface mod12_count_checker_if #(
  parameter int ERR_W = 8
);
  logic             en;
  logic             UpOrDown;
  logic [3:0]       Count;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic             wrap_up;
  logic             wrap_down;

  modport master (
    output en, UpOrDown, Count, clr_err,
    input  locked, err, err_count, wrap_up, wrap_down
  );

  modport slave (
    input  en, UpOrDown, Count, clr_err,
    output locked, err, err_count, wrap_up, wrap_down
  );
endinterface

// File: rtl/mod12_count_checker.sv
// Receive-side checker for an up/down modulo counter stream: acquires and locks onto
// the sequence, flags sequence errors, counts them (saturating) and reports wraps.
module mod12_count_checker #(
  parameter int MODULUS  = 12,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input logic                 Clk,
  input logic                 reset,
  mod12_count_checker_if.slave bus
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [3:0]       LAST_VAL = 4'(MODULUS - 1);
  localparam logic [4:0]       MOD_VAL  = 5'(MODULUS);
  localparam logic [MC_W-1:0]  LOCK_TGT = MC_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic             dir_q, dir_d;
  logic [MC_W-1:0]  match_q, match_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_down_q, wrap_down_d;

  logic [3:0]       exp_s;
  logic             valid_s;
  logic             match_s;
  logic             err_hit_s;
  logic [ERR_W-1:0] err_base_s;

  // Value the counter should present next, given the last sample and its direction.
  function automatic logic [3:0] step_exp(input logic [3:0] p, input logic d);
    logic [3:0] r;
    if (d) begin
      if (p == LAST_VAL) r = 4'd0;
      else               r = p + 4'd1;
    end else begin
      if (p == 4'd0)     r = LAST_VAL;
      else               r = p - 4'd1;
    end
    return r;
  endfunction

  assign exp_s   = step_exp(prev_q, dir_q);
  assign valid_s = ({1'b0, bus.Count} < MOD_VAL);
  assign match_s = valid_s && (bus.Count == exp_s);

  // Next-state, tracking registers, pulse outputs and error counter.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    dir_d       = dir_q;
    match_d     = match_q;
    err_d       = 1'b0;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    err_hit_s   = 1'b0;
    if (bus.en) begin
      case (state_q)
        ST_SYNC: begin
          if (valid_s) begin
            prev_d  = bus.Count;
            dir_d   = bus.UpOrDown;
            match_d = '0;
            state_d = ST_ACQ;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_ACQ: begin
          if (match_s) begin
            prev_d = bus.Count;
            dir_d  = bus.UpOrDown;
            if ((match_q + MC_W'(1)) == LOCK_TGT) begin
              match_d = '0;
              state_d = ST_LOCKED;
            end else begin
              match_d = match_q + MC_W'(1);
            end
          end else if (valid_s) begin
            prev_d  = bus.Count;
            dir_d   = bus.UpOrDown;
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            prev_d      = bus.Count;
            dir_d       = bus.UpOrDown;
            wrap_up_d   = dir_q && (prev_q == LAST_VAL) && (bus.Count == 4'd0);
            wrap_down_d = !dir_q && (prev_q == 4'd0) && (bus.Count == LAST_VAL);
          end else begin
            err_d     = 1'b1;
            err_hit_s = 1'b1;
            match_d   = '0;
            if (valid_s) begin
              prev_d  = bus.Count;
              dir_d   = bus.UpOrDown;
              state_d = ST_ACQ;
            end else begin
              state_d = ST_SYNC;
            end
          end
        end
        default: begin
          match_d = '0;
          state_d = ST_SYNC;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Clear applies first so a coincident error still lands as a count of one.
    if (bus.clr_err) begin
      err_base_s = '0;
    end else begin
      err_base_s = err_cnt_q;
    end
    if (err_hit_s && (err_base_s != ERR_MAX)) begin
      err_cnt_d = err_base_s + ERR_W'(1);
    end else begin
      err_cnt_d = err_base_s;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs; reset asserts asynchronously.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      prev_q      <= 4'd0;
      dir_q       <= 1'b0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dir_q       <= dir_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;
  assign bus.wrap_up   = wrap_up_q;
  assign bus.wrap_down = wrap_down_q;

endmodule

// File: tb/tb_mod12_count_checker.sv
// Directed and randomized bench for mod12_count_checker (MODULUS=12, ERR_W=2, LOCK_CNT=2),
// checked against a behavioural model of the stream rules.
module tb_mod12_count_checker;
  localparam int M     = 12;
  localparam int EW    = 2;
  localparam int LK    = 2;
  localparam int MAXC  = (1 << EW) - 1;

  logic Clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mod12_count_checker_if #(.ERR_W(EW)) bus_if();

  mod12_count_checker #(.MODULUS(M), .ERR_W(EW), .LOCK_CNT(LK)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: "have_ref" = a previous valid sample is held, "run" = consecutive hits.
  int m_prev, m_dir, m_have, m_lock, m_run, m_cnt;
  int m_err, m_wu, m_wd;
  int wu_seen, wd_seen, err_seen;

  task automatic model_reset();
    m_prev = 0; m_dir = 0; m_have = 0; m_lock = 0; m_run = 0; m_cnt = 0;
    m_err = 0; m_wu = 0; m_wd = 0;
  endtask

  task automatic model_step(input int e, input int ud, input int c, input int clr);
    int expv, valid, hit, fail;
    m_err = 0; m_wu = 0; m_wd = 0; fail = 0;
    if (e != 0) begin
      valid = (c < M);
      expv  = (m_dir != 0) ? (m_prev + 1) % M : (m_prev + M - 1) % M;
      hit   = valid && (c == expv);
      if (m_have == 0) begin
        if (valid) begin m_prev = c; m_dir = ud; m_have = 1; m_run = 0; end
      end else if (m_lock != 0) begin
        if (hit) begin
          m_wu = (m_prev == M - 1 && m_dir == 1 && c == 0);
          m_wd = (m_prev == 0 && m_dir == 0 && c == M - 1);
          m_prev = c; m_dir = ud;
        end else begin
          m_err = 1; fail = 1; m_lock = 0; m_run = 0;
          if (valid) begin m_prev = c; m_dir = ud; end
          else m_have = 0;
        end
      end else begin
        if (hit) begin
          m_run++; m_prev = c; m_dir = ud;
          if (m_run == LK) begin m_lock = 1; m_run = 0; end
        end else if (valid) begin
          m_prev = c; m_dir = ud; m_run = 0;
        end else begin
          m_have = 0; m_run = 0;
        end
      end
    end
    if (clr != 0) m_cnt = 0;
    if (fail && m_cnt < MAXC) m_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".locked"},    32'(bus_if.locked),    32'(m_lock));
    chk({tag, ".err"},       32'(bus_if.err),       32'(m_err));
    chk({tag, ".err_count"}, 32'(bus_if.err_count), 32'(m_cnt));
    chk({tag, ".wrap_up"},   32'(bus_if.wrap_up),   32'(m_wu));
    chk({tag, ".wrap_down"}, 32'(bus_if.wrap_down), 32'(m_wd));
  endtask

  task automatic step(input int e, input int ud, input int c, input int clr, input string tag);
    bus_if.en       = 1'(e);
    bus_if.UpOrDown = 1'(ud);
    bus_if.Count    = 4'(c);
    bus_if.clr_err  = 1'(clr);
    @(posedge Clk);
    model_step(e, ud, c, clr);
    #1;
    chk_all(tag);
    wu_seen  += int'(bus_if.wrap_up);
    wd_seen  += int'(bus_if.wrap_down);
    err_seen += int'(bus_if.err);
  endtask

  int gv, gd, cv, e, clr;

  initial begin
    reset = 1'b0;
    bus_if.en = 1'b0; bus_if.UpOrDown = 1'b0; bus_if.Count = 4'd0; bus_if.clr_err = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    reset = 1'b1;

    // Clean up-count with one wrap; lock after sample index 2.
    wu_seen = 0; wd_seen = 0; err_seen = 0;
    for (int i = 0; i < 14; i++) begin
      step(1, 1, i % M, 0, "up");
      if (i == 1) chk("up_unlocked_s1", 32'(bus_if.locked), 32'd0);
      if (i == 2) chk("up_locked_s2", 32'(bus_if.locked), 32'd1);
    end
    chk("up_wrap_once", 32'(wu_seen), 32'd1);
    chk("up_err_count", 32'(bus_if.err_count), 32'd0);

    // Direction change while locked, then down run with one down-wrap.
    for (int v = 2; v <= 9; v++) step(1, 1, v, 0, "up2");
    step(1, 0, 10, 0, "turn");
    wu_seen = 0; wd_seen = 0;
    for (int v = 9; v >= 0; v--) step(1, 0, v, 0, "down");
    step(1, 0, 11, 0, "down");
    step(1, 0, 10, 0, "down");
    chk("dir_no_err", 32'(err_seen), 32'd0);
    chk("dir_locked", 32'(bus_if.locked), 32'd1);
    chk("down_wrap_once", 32'(wd_seen), 32'd1);
    chk("down_no_wrap_up", 32'(wu_seen), 32'd0);

    // Fault injection: 5,6 then 9 instead of 7.
    for (int v = 9; v >= 6; v--) step(1, 0, v, 0, "down2");
    step(1, 1, 5, 0, "fi5");
    step(1, 1, 6, 0, "fi6");
    step(1, 1, 9, 0, "fi9");
    chk("fault_err", 32'(bus_if.err), 32'd1);
    chk("fault_cnt", 32'(bus_if.err_count), 32'd1);
    chk("fault_unlock", 32'(bus_if.locked), 32'd0);
    step(1, 1, 10, 0, "fi10");
    chk("fault_err_one_cycle", 32'(bus_if.err), 32'd0);
    step(1, 1, 11, 0, "fi11");
    chk("fault_relock", 32'(bus_if.locked), 32'd1);

    // Out-of-range samples saturate a 2-bit counter; clear coincides with a fifth error.
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 13, 0, "oor");
      for (int v = 0; v < 3; v++) step(1, 1, v, 0, "oor_relock");
    end
    chk("sat_cnt", 32'(bus_if.err_count), 32'd3);
    step(1, 1, 13, 1, "clr_err");
    chk("clr_plus_err", 32'(bus_if.err_count), 32'd1);
    for (int v = 0; v < 3; v++) step(1, 1, v, 0, "relock");

    // Enable low: state and outputs hold while Count wanders.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, $urandom_range(0, 15), 0, "hold");
      chk("hold_locked", 32'(bus_if.locked), 32'd1);
    end
    step(1, 1, 3, 0, "resume");
    chk("resume_no_err", 32'(bus_if.err), 32'd0);

    // Asynchronous reset mid-cycle while locked.
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all("midreset");
    #3;
    reset = 1'b1;
    step(1, 1, 5, 0, "post_rst");
    step(1, 1, 6, 0, "post_rst");
    chk("post_rst_sync", 32'(bus_if.locked), 32'd0);
    step(1, 1, 7, 0, "post_rst");

    // Randomized stream: direction flips, glitches, enable gaps, clears.
    gv = 7; gd = 1;
    for (int n = 0; n < 400; n++) begin
      e   = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 31) == 0);
      cv  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : gv;
      step(e, gd, cv, clr, "rand");
      if (e != 0) begin
        gv = (gd != 0) ? (gv + 1) % M : (gv + M - 1) % M;
        if ($urandom_range(0, 7) == 0) gd = 1 - gd;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
